// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access encodings, FSM states and lane widths.
// The optional bounds check is enabled by defining LSU_BOUNDS_CHECK_EN.
package lsu_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam int LANE_BYTE_W = 8;
  localparam int HALF_W      = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE
  } lsu_state_e;

  // Halfwords need an even address, words need a 4-byte aligned address.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic mis;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = lane[0];
      OP_LW, OP_SW:         mis = |lane;
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: load extraction with sign/zero extension, and the
// byte/halfword merge used by the read-modify-write store path.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic [2:0]        op_i,
  input  logic [1:0]        lane_i,
  input  logic [HALF_W-1:0] wdata_i,
  output logic [31:0]       load_data_o,
  output logic [31:0]       merged_o
);

  logic [LANE_BYTE_W-1:0] byteSel;
  logic [HALF_W-1:0]      halfSel;

  always_comb begin
    byteSel = word_i[{lane_i, 3'b000} +: LANE_BYTE_W];
    halfSel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (op_i)
      OP_LB:   load_data_o = {{(32-LANE_BYTE_W){byteSel[LANE_BYTE_W-1]}}, byteSel};
      OP_LBU:  load_data_o = {{(32-LANE_BYTE_W){1'b0}}, byteSel};
      OP_LH:   load_data_o = {{(32-HALF_W){halfSel[HALF_W-1]}}, halfSel};
      OP_LHU:  load_data_o = {{(32-HALF_W){1'b0}}, halfSel};
      OP_LW:   load_data_o = word_i;
      default: load_data_o = '0;
    endcase

    // Untouched lanes keep the word read back from memory.
    merged_o = word_i;
    if (op_i == OP_SB) begin
      merged_o[{lane_i, 3'b000} +: LANE_BYTE_W] = wdata_i[LANE_BYTE_W-1:0];
    end else if (op_i == OP_SH) begin
      merged_o[{lane_i[1], 4'b0000} +: HALF_W] = wdata_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end for the word-addressed Data_Memory.
// Define LSU_BOUNDS_CHECK_EN to fault on accesses beyond MEM_WORDS instead of truncating the index.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = 8192,
  parameter int WORD_IDX_W = 13
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign,
  output logic        access_fault,
  output logic        stall,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  lsu_state_e            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [1:0]            lane_q, lane_d;
  logic [WORD_IDX_W-1:0] wordIdx_q, wordIdx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rspValid_q, rspValid_d;
  logic                  misalign_q, misalign_d;
  logic                  fault_q, fault_d;

  logic                  reqMisaligned;
  logic                  addrOutOfRange;
  logic                  reqFault;
  logic [31:0]           alignWord;
  logic [31:0]           loadData;
  logic [31:0]           mergedWord;

  assign reqMisaligned  = is_misaligned(req_op, req_addr[1:0]);
  assign addrOutOfRange = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

`ifdef LSU_BOUNDS_CHECK_EN
  assign reqFault = addrOutOfRange;
`else
  logic unusedBoundsCheck;
  assign unusedBoundsCheck = addrOutOfRange;
  assign reqFault          = 1'b0;
`endif

  assign req_ready      = (state_q == S_IDLE);
  assign stall          = req_valid & ~req_ready;
  assign mem_read       = (state_q == S_LOAD) || (state_q == S_RMW_READ);
  assign mem_write      = (state_q == S_WRITE);
  assign mem_write_data = mem_write ? wdata_q : '0;
  assign mem_address    = {{(32-WORD_IDX_W){1'b0}}, wordIdx_q};
  assign rsp_valid      = rspValid_q;
  assign rsp_rdata      = rdata_q;
  assign misalign       = misalign_q;
  assign access_fault   = fault_q;

  // Memory read data is only meaningful while mem_read is high; mask it otherwise.
  assign alignWord = mem_read ? mem_read_data : '0;

  lsu_lane_align u_lane_align (
    .word_i      (alignWord),
    .op_i        (op_q),
    .lane_i      (lane_q),
    .wdata_i     (wdata_q[HALF_W-1:0]),
    .load_data_o (loadData),
    .merged_o    (mergedWord)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    lane_d     = lane_q;
    wordIdx_d  = wordIdx_q;
    wdata_d    = wdata_q;
    rdata_d    = '0;
    rspValid_d = 1'b0;
    misalign_d = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          lane_d    = req_addr[1:0];
          wordIdx_d = req_addr[WORD_IDX_W+1:2];
          wdata_d   = req_wdata;
          // Rejected requests answer next cycle without touching memory; misalign wins.
          if (reqMisaligned) begin
            rspValid_d = 1'b1;
            misalign_d = 1'b1;
          end else if (reqFault) begin
            rspValid_d = 1'b1;
            fault_d    = 1'b1;
          end else begin
            case (req_op)
              OP_SW:        state_d = S_WRITE;
              OP_SB, OP_SH: state_d = S_RMW_READ;
              default:      state_d = S_LOAD;
            endcase
          end
        end
      end
      S_LOAD: begin
        rdata_d    = loadData;
        rspValid_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_RMW_READ: begin
        wdata_d = mergedWord;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        rspValid_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LB;
      lane_q     <= '0;
      wordIdx_q  <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rspValid_q <= 1'b0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      lane_q     <= lane_d;
      wordIdx_q  <= wordIdx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rspValid_q <= rspValid_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end sitting directly upstream of Data_Memory; consumes EX/MEM load/store requests and drives the word-addressed data RAM.
- Translates byte addresses to word indices and performs byte/halfword lane extraction with sign/zero extension on loads.
- Implements sub-word stores as a 2-cycle read-modify-write.
- Flags misaligned accesses; stalls the pipeline while busy.

Parameters:
- MEM_WORDS, 8192, depth of Data_Memory in 32-bit words (used by the bounds check).
- WORD_IDX_W, 13, width of the word index, equal to clog2(MEM_WORDS).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  EX/MEM presents an access.
- req_ready  out  1  unit accepts a request this cycle.
- req_op  in  3  access type: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data; sub-word data is in the low bits.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and faults.
- misalign  out  1  valid with rsp_valid; access was misaligned.
- access_fault  out  1  valid with rsp_valid; out-of-range access (see Optional Feature).
- stall  out  1  equals req_valid & ~req_ready.
- mem_address  out  32  word index, zero-extended.
- mem_write_data  out  32  word to write.
- mem_write  out  1  write strobe, sampled by Data_Memory on the clock edge.
- mem_read  out  1  read enable; Data_Memory read data is combinational while high.
- mem_read_data  in  32  Data_Memory output; X whenever mem_read is low.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - LOAD
  - RMW_READ
  - WRITE
  - req_ready=0 in every state other than IDLE.
- Reset (asynchronous): state=IDLE; every output 0, except req_ready=1 and stall=req_valid. Any in-flight operation is discarded and produces no rsp_valid. mem_write drops immediately on reset assertion.
- Accept: req_valid & req_ready in IDLE. On accept, the unit registers op, addr[1:0], wdata and word index = req_addr[WORD_IDX_W+1:2].
- Alignment:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - A misaligned request stays in IDLE and raises no mem_read or mem_write.
  - Next cycle: rsp_valid=1, misalign=1, rsp_rdata=0.
- Loads: IDLE → LOAD.
  - In LOAD: mem_read=1 and mem_address=index.
  - mem_read_data is sampled only in LOAD or RMW_READ, never otherwise.
  - End of LOAD: extract the lane and register it into rsp_rdata; go to IDLE.
  - rsp_valid pulses in that IDLE cycle. Latency: accept cycle N → rsp_valid in cycle N+2.
- Lane rules (little-endian):
  - Byte lane k=addr[1:0] maps to bits [8k+7:8k].
  - Halfword: addr[1]=0 maps to [15:0]; addr[1]=1 maps to [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW: IDLE → WRITE.
  - In WRITE: mem_write=1 and mem_write_data=wdata for exactly one cycle.
  - Then IDLE with the rsp_valid pulse.
- SB/SH: IDLE → RMW_READ → WRITE → IDLE.
  - In RMW_READ: mem_read=1 and the merged word is registered (selected lane replaced by wdata[7:0] or wdata[15:0], other lanes preserved).
  - In WRITE: the merged word is written.
  - rsp_valid pulses at cycle N+3.
- Output discipline: mem_read and mem_write are never high in the same cycle. mem_address holds its value through RMW_READ and WRITE.
- Back-to-back: a new request may be accepted in the same IDLE cycle that carries rsp_valid for the previous request.
- rsp_valid with rsp_rdata=0 acknowledges stores.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined:
  - req_addr[31:2] >= MEM_WORDS is treated like a misalignment: no memory access.
  - Next cycle: rsp_valid=1, access_fault=1, rsp_rdata=0.
  - If a request is both misaligned and out of range, misalign takes priority and access_fault stays 0.
- Undefined: access_fault is tied to 0 and the index silently truncates to WORD_IDX_W bits.

Decomposition:
- Package lsu_pkg:
  - req_op encodings (OP_LB…OP_SW).
  - State enum.
  - Helper constants LANE_BYTE_W=8 and HALF_W=16.
- Sub-module lsu_lane_align (combinational): computes load extract/extend and store merge from word, op, addr[1:0] and wdata. It is shared by LOAD and RMW_READ.

Test Plan:
- After reset with RAM holding its initial values (word i = i): LW 0x14 → rsp_valid at N+2, rsp_rdata=0x00000005, mem_address=5.
- SW 0x100 with 0x8899AABB, then LB 0x102 → 0xFFFFFF99; LBU 0x102 → 0x00000099; LH 0x102 → 0xFFFF8899; LHU 0x100 → 0x0000AABB.
- Word 0x40 preloaded with 0x11223344, then SB 0x41 with 0x12:
  - RMW_READ then WRITE cycles are observed.
  - mem_write_data=0x11221244 and rsp_valid at N+3.
  - A following LW 0x40 returns 0x11221244.
- LW 0x102 and SH 0x103 → misalign=1 at N+1; mem_read and mem_write are never asserted; stall=0 afterward.
- Assert reset during the RMW_READ cycle of SB 0x41 → mem_write never pulses, word 0x10 is unchanged, no rsp_valid, and req_ready=1 immediately.
- With LSU_BOUNDS_CHECK_EN: LW 0x00008000 (index 8192) → access_fault=1, rsp_rdata=0, no mem_read. Without the macro, the same access reads index 0.
